// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program-memory port, redirect request from execute and the
// valid/ready instruction channel toward decode.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect_vld;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic                  halted;
  logic                  misalign_err;

  // Fetch stage side
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted, misalign_err,
    input  imem_data, redirect_vld, redirect_pc, if_ready
  );

  // Surrounding pipeline / memory side
  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted, misalign_err,
    output imem_data, redirect_vld, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the async program memory and
// registers the returned word plus its PC toward decode. Supports redirects
// (which flush any pending instruction) and stops fetching on EBREAK.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'h00100073
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_HALT
  } state_t;

  state_t                state_reg,    state_next;
  logic [ADDR_WIDTH-1:0] pc_reg,       pc_next;
  logic                  valid_reg,    valid_next;
  logic [DATA_WIDTH-1:0] instr_reg,    instr_next;
  logic [ADDR_WIDTH-1:0] ipc_reg,      ipc_next;
  logic                  halted_reg,   halted_next;
  logic                  misalign_reg, misalign_next;

  // Output slot is free when empty or being consumed this cycle.
  logic advance;
  assign advance = !valid_reg || bus.if_ready;

  assign bus.imem_addr    = pc_reg;
  assign bus.if_valid     = valid_reg;
  assign bus.if_instr     = instr_reg;
  assign bus.if_pc        = ipc_reg;
  assign bus.halted       = halted_reg;
  assign bus.misalign_err = misalign_reg;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_WAIT;
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      ipc_reg      <= '0;
      halted_reg   <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      ipc_reg      <= ipc_next;
      halted_reg   <= halted_next;
      misalign_reg <= misalign_next;
    end
  end

  // Next-state logic: fetch/stall/halt per state, redirect overrides all but WAIT.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    ipc_next      = ipc_reg;
    halted_next   = halted_reg;
    misalign_next = misalign_reg;

    case (state_reg)
      S_WAIT: begin
        // Memory contents settle for one cycle after reset; no fetch.
        state_next = S_RUN;
      end
      S_RUN: begin
        if (advance) begin
          instr_next = bus.imem_data;
          ipc_next   = pc_reg;
          valid_next = 1'b1;
          if (bus.imem_data == HALT_INSTR) begin
            // PC parks on the halt instruction.
            state_next  = S_HALT;
            halted_next = 1'b1;
          end else begin
            pc_next = pc_reg + ADDR_WIDTH'(4);
          end
        end
      end
      S_HALT: begin
        // Drain the final instruction, then go quiet.
        if (valid_reg && bus.if_ready) begin
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase

    // Redirect flushes the output slot even if decode is accepting it now.
    if (bus.redirect_vld && (state_reg != S_WAIT)) begin
      pc_next     = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      valid_next  = 1'b0;
      instr_next  = instr_reg;
      ipc_next    = ipc_reg;
      state_next  = S_RUN;
      halted_next = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, stall, redirect/flush,
// misaligned redirect, EBREAK halt, PC wrap and asynchronous mid-run reset.
module tb_instr_fetch;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam logic [31:0] HALT = 32'h00100073;

  logic clk;
  logic rst_n;
  logic [31:0] mem [0:511];

  int passed;
  int total;

  instr_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  ('0),
    .HALT_INSTR(HALT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Asynchronous program memory model
  assign bus.imem_data = mem[bus.imem_addr[AW-1:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: active edge, then sample point on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({tag, ".vld"}, {31'd0, bus.if_valid}, {31'd0, v});
    chk({tag, ".pc"}, {21'd0, bus.if_pc}, pc);
    chk({tag, ".ins"}, bus.if_instr, ins);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + i;
    rst_n            = 1'b0;
    bus.if_ready     = 1'b1;
    bus.redirect_vld = 1'b0;
    bus.redirect_pc  = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk_out("rst", 1'b0, 32'h0, 32'h0);
    chk("rst.halt", {31'd0, bus.halted}, 32'd0);
    chk("rst.mis", {31'd0, bus.misalign_err}, 32'd0);
    chk("rst.addr", {21'd0, bus.imem_addr}, 32'h0);

    // 1: WAIT cycle then stream 0,4,8
    rst_n = 1'b1;
    tick();
    chk("wait.vld", {31'd0, bus.if_valid}, 32'd0);
    tick(); chk_out("s0", 1'b1, 32'h0, 32'hA000_0000);
    tick(); chk_out("s4", 1'b1, 32'h4, 32'hA000_0001);
    tick(); chk_out("s8", 1'b1, 32'h8, 32'hA000_0002);

    // 2: stall 3 cycles at 8
    bus.if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("stall", 1'b1, 32'h8, 32'hA000_0002);
      chk("stall.addr", {21'd0, bus.imem_addr}, 32'hC);
    end
    bus.if_ready = 1'b1;
    tick(); chk_out("s12", 1'b1, 32'hC, 32'hA000_0003);

    // 3: redirect to 0x40 while pending and not accepted
    bus.if_ready     = 1'b0;
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h040;
    tick();
    bus.redirect_vld = 1'b0;
    chk("flush.vld", {31'd0, bus.if_valid}, 32'd0);
    chk("flush.addr", {21'd0, bus.imem_addr}, 32'h40);
    tick(); chk_out("r40", 1'b1, 32'h40, 32'hA000_0010);
    bus.if_ready = 1'b1;

    // 4: misaligned redirect to 0x42
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h042;
    tick();
    bus.redirect_vld = 1'b0;
    chk("mis.set", {31'd0, bus.misalign_err}, 32'd1);
    chk("mis.vld", {31'd0, bus.if_valid}, 32'd0);
    tick(); chk_out("m40", 1'b1, 32'h40, 32'hA000_0010);
    tick(); chk_out("m44", 1'b1, 32'h44, 32'hA000_0011);
    chk("mis.stick", {31'd0, bus.misalign_err}, 32'd1);

    // 5: EBREAK at 0x14
    mem[5] = HALT;
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h00C;
    tick();
    bus.redirect_vld = 1'b0;
    tick(); chk_out("h0c", 1'b1, 32'hC, 32'hA000_0003);
    tick(); chk_out("h10", 1'b1, 32'h10, 32'hA000_0004);
    tick(); chk_out("h14", 1'b1, 32'h14, HALT);
    chk("halt.set", {31'd0, bus.halted}, 32'd1);
    chk("halt.addr", {21'd0, bus.imem_addr}, 32'h14);
    bus.if_ready = 1'b0;
    tick(); chk_out("hhold", 1'b1, 32'h14, HALT);
    bus.if_ready = 1'b1;
    tick();
    chk("halt.drain", {31'd0, bus.if_valid}, 32'd0);
    tick();
    chk("halt.quiet", {31'd0, bus.if_valid}, 32'd0);
    chk("halt.still", {31'd0, bus.halted}, 32'd1);
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h000;
    tick();
    bus.redirect_vld = 1'b0;
    chk("halt.clr", {31'd0, bus.halted}, 32'd0);
    tick(); chk_out("hr0", 1'b1, 32'h0, 32'hA000_0000);

    // 6: PC wrap from 0x7FC
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h7FC;
    tick();
    bus.redirect_vld = 1'b0;
    tick(); chk_out("w7fc", 1'b1, 32'h7FC, 32'hA000_01FF);
    chk("wrap.addr", {21'd0, bus.imem_addr}, 32'h0);
    tick(); chk_out("w0", 1'b1, 32'h0, 32'hA000_0000);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0, 32'h0);
    chk("arst.mis", {31'd0, bus.misalign_err}, 32'd0);
    chk("arst.addr", {21'd0, bus.imem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Redirect during WAIT is dropped
    bus.redirect_vld = 1'b1;
    bus.redirect_pc  = 11'h042;
    tick();
    bus.redirect_vld = 1'b0;
    chk("rwait.vld", {31'd0, bus.if_valid}, 32'd0);
    chk("rwait.mis", {31'd0, bus.misalign_err}, 32'd0);
    tick(); chk_out("re0", 1'b1, 32'h0, 32'hA000_0000);
    tick(); chk_out("re4", 1'b1, 32'h4, 32'hA000_0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
